pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Central sequencer for the five-stage RV32E pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. Each cycle it decides whether every stage advances, holds, or is replaced by a bubble, based on three conditions:
- load-use and RAW hazards detected in ID;
- taken branches or jumps resolved in EX;
- an outstanding LSU access in MEM that has not yet been acknowledged.

A small FSM sequences multi-cycle redirects and memory waits, with a watchdog and a stall-cycle counter.

## Interface
Parameters:
- REDIRECT_FLUSH_CYCLES, 2, cycles IF/ID is flushed after a redirect (fetch latency); range 1–7.
- MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before mem_fault; range 1–65535.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- rs1_ID, rs2_ID  in  4  source register indices of the instruction in ID.
- rs1_used_ID, rs2_used_ID  in  1  source actually read by the instruction in ID.
- rd_EX  in  4  destination register of the instruction in EX.
- regfile_we_EX  in  1  EX instruction writes the register file.
- rd_data_sel_EX  in  2  writeback source of EX; the LSU encoding marks a load.
- rd_MEM  in  4  destination register of the instruction in MEM.
- regfile_we_MEM  in  1  MEM instruction writes the register file.
- branch_taken_EX  in  1  EX redirects the PC this cycle.
- lsu_req_MEM  in  1  MEM holds a valid load or store.
- lsu_ack_MEM  in  1  LSU completes that access this cycle.
- pc_hold, if_id_hold, id_ex_hold, ex_mem_hold  out  1  the stage keeps its current contents.
- if_id_flush, id_ex_bubble, mem_wb_bubble  out  1  the stage loads an invalid/no-op entry.
- mem_fault  out  1  one-cycle pulse when the watchdog expires.
- stall_count  out  32  cycles with pc_hold=1 since reset; wraps modulo 2^32.

## Operation
FSM states: RUN, MEM_WAIT, REDIRECT.

Priority is evaluated every cycle, highest first:
1. **Memory wait.** If lsu_req_MEM=1 and lsu_ack_MEM=0:
   - assert pc_hold, if_id_hold, id_ex_hold, ex_mem_hold and mem_wb_bubble;
   - enter or stay in MEM_WAIT; wait_cnt increments each cycle.
   - A branch_taken_EX seen during this cycle is ignored; EX is held, so it is re-presented later.
2. **Redirect.** If branch_taken_EX=1:
   - assert if_id_flush and id_ex_bubble;
   - go to REDIRECT with flush_cnt = REDIRECT_FLUSH_CYCLES-1.
   - If that value is 0, return to RUN on the next cycle.
3. **Data hazard** (a hazard exists when an rs*_used_ID source matches the rd index, and that rd is nonzero):
   - Load-use: ID source matches rd_EX, regfile_we_EX=1, and rd_data_sel_EX is the LSU encoding.
   - Response: assert pc_hold, if_id_hold and id_ex_bubble for one cycle; the state stays RUN.

REDIRECT state:
- if_id_flush=1 each cycle; flush_cnt decrements; return to RUN when it reaches 0.
- A new branch_taken_EX while in REDIRECT reloads flush_cnt.
- Memory wait still preempts REDIRECT; flush_cnt is frozen during the wait.

MEM_WAIT state:
- Exit to RUN, or to REDIRECT if flush_cnt≠0, on lsu_ack_MEM=1. On that cycle all holds drop.
- If wait_cnt reaches MEM_TIMEOUT: pulse mem_fault, force mem_wb_bubble, release the holds, clear wait_cnt and go to RUN.

Index 0 never creates a hazard.

## Timing
- All hold, flush and bubble outputs are combinational from the current state and inputs, so they act in the same cycle as the detecting condition.
- State, counters and mem_fault are registered.
- Load-use costs exactly 1 bubble.
- A taken branch costs 1 + REDIRECT_FLUSH_CYCLES-1 flushed IF/ID slots.
- While rst=1:
  - if_id_flush, id_ex_bubble and mem_wb_bubble are 1; all holds and mem_fault are 0;
  - the state goes to RUN; flush_cnt, wait_cnt and stall_count are cleared.
- Reset asserted mid-MEM_WAIT or mid-REDIRECT aborts the sequence immediately.
- stall_count increments when pc_hold=1. It wraps from 0xFFFFFFFF to 0.

## Configuration
- HAZARD_FORWARDING_EN defined: an EX/MEM→EX forwarding path exists, and only load-use (rule 3) stalls.
- Undefined: any ID source matching a writing rd_EX or rd_MEM (nonzero) stalls. Each such cycle asserts pc_hold, if_id_hold and id_ex_bubble, and the stall repeats until no match remains.

## Structure
- The FSM state enum and the LSU rd_data_sel encoding belong in the shared core package/defines, next to the branch-condition constants.
- Hazard comparison is one natural sub-module, hazard_detect: purely combinational, it outputs load_use and raw_stall.
- The FSM, counters and output muxing stay in the top module.

## Test plan
- Load to x5 in EX; ID reads rs1=x5 → one cycle of pc_hold=if_id_hold=id_ex_bubble=1, then free flow; stall_count=1.
- branch_taken_EX with REDIRECT_FLUSH_CYCLES=2 → if_id_flush=1 for 2 consecutive cycles, id_ex_bubble=1 on the first cycle only.
- lsu_req_MEM=1, ack after 4 cycles with branch_taken_EX=1 held in EX → 4 cycles with all holds asserted, then the redirect sequence runs.
- No ack with MEM_TIMEOUT=8 → mem_fault pulses once in cycle 8, then RUN.
- Without HAZARD_FORWARDING_EN: ALU write to x3 in EX, ID reads x3 → 2 stall cycles. With the macro defined → 0 stall cycles.
- rst pulsed during MEM_WAIT → next cycle RUN, holds=0, stall_count=0.

Source files
------------

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared core definitions for the pipeline hazard controller: FSM states, writeback
// source encoding, branch-condition constants and the register-match helper.
package pipeline_hazard_controller_pkg;

  localparam int REG_IDX_W   = 4;
  localparam int RD_SEL_W    = 2;
  localparam int FLUSH_CNT_W = 3;
  localparam int WAIT_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIRECT = 2'd2
  } hz_state_e;

  localparam logic [RD_SEL_W-1:0] RD_SEL_ALU = 2'd0;
  localparam logic [RD_SEL_W-1:0] RD_SEL_LSU = 2'd1;
  localparam logic [RD_SEL_W-1:0] RD_SEL_PC4 = 2'd2;
  localparam logic [RD_SEL_W-1:0] RD_SEL_IMM = 2'd3;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LT  = 3'd4,
    BR_GE  = 3'd5,
    BR_LTU = 3'd6,
    BR_GEU = 3'd7
  } br_cond_e;

  // x0 is hardwired to zero, so it can never be the subject of a hazard.
  function automatic logic src_hit(input logic [REG_IDX_W-1:0] rs,
                                   input logic                 used,
                                   input logic [REG_IDX_W-1:0] rd);
    return used && (rs == rd) && (rd != '0);
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline-side view of the hazard controller: hazard sources in, stage controls out.
interface pipeline_hazard_controller_if;
  import pipeline_hazard_controller_pkg::*;

  logic [REG_IDX_W-1:0] rs1_ID;
  logic [REG_IDX_W-1:0] rs2_ID;
  logic                 rs1_used_ID;
  logic                 rs2_used_ID;
  logic [REG_IDX_W-1:0] rd_EX;
  logic                 regfile_we_EX;
  logic [RD_SEL_W-1:0]  rd_data_sel_EX;
  logic [REG_IDX_W-1:0] rd_MEM;
  logic                 regfile_we_MEM;
  logic                 branch_taken_EX;
  logic                 lsu_req_MEM;
  logic                 lsu_ack_MEM;

  logic                 pc_hold;
  logic                 if_id_hold;
  logic                 id_ex_hold;
  logic                 ex_mem_hold;
  logic                 if_id_flush;
  logic                 id_ex_bubble;
  logic                 mem_wb_bubble;
  logic                 mem_fault;
  logic [31:0]          stall_count;

  modport master (
    output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID,
           rd_EX, regfile_we_EX, rd_data_sel_EX,
           rd_MEM, regfile_we_MEM,
           branch_taken_EX, lsu_req_MEM, lsu_ack_MEM,
    input  pc_hold, if_id_hold, id_ex_hold, ex_mem_hold,
           if_id_flush, id_ex_bubble, mem_wb_bubble,
           mem_fault, stall_count
  );

  modport slave (
    input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID,
           rd_EX, regfile_we_EX, rd_data_sel_EX,
           rd_MEM, regfile_we_MEM,
           branch_taken_EX, lsu_req_MEM, lsu_ack_MEM,
    output pc_hold, if_id_hold, id_ex_hold, ex_mem_hold,
           if_id_flush, id_ex_bubble, mem_wb_bubble,
           mem_fault, stall_count
  );

endinterface

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// Combinational ID-stage hazard comparison. With HAZARD_FORWARDING_EN defined only
// load-use stalls; otherwise any match against a writing EX or MEM destination stalls.
module hazard_detect
  import pipeline_hazard_controller_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs1_id,
  input  logic [REG_IDX_W-1:0] rs2_id,
  input  logic                 rs1_used_id,
  input  logic                 rs2_used_id,
  input  logic [REG_IDX_W-1:0] rd_ex,
  input  logic                 we_ex,
  input  logic [RD_SEL_W-1:0]  rd_sel_ex,
  input  logic [REG_IDX_W-1:0] rd_mem,
  input  logic                 we_mem,
  output logic                 load_use,
  output logic                 raw_stall
);

  logic hit_ex;

  assign hit_ex   = we_ex && (src_hit(rs1_id, rs1_used_id, rd_ex) ||
                              src_hit(rs2_id, rs2_used_id, rd_ex));
  assign load_use = hit_ex && (rd_sel_ex == RD_SEL_LSU);

`ifdef HAZARD_FORWARDING_EN
  // The MEM destination is covered by the forwarding network in this build.
  logic unused_mem;
  assign unused_mem = ^{rd_mem, we_mem};
  assign raw_stall  = 1'b0;
`else
  logic hit_mem;
  assign hit_mem   = we_mem && (src_hit(rs1_id, rs1_used_id, rd_mem) ||
                                src_hit(rs2_id, rs2_used_id, rd_mem));
  assign raw_stall = hit_ex || hit_mem;
`endif

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the five-stage RV32E pipeline.
// Optional feature macro: HAZARD_FORWARDING_EN (see hazard_detect).
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REDIRECT_FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT           = 255
) (
  input logic                          clk,
  input logic                          rst,
  pipeline_hazard_controller_if.slave  bus
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(REDIRECT_FLUSH_CYCLES - 1);
  localparam logic [WAIT_CNT_W-1:0]  WAIT_LIMIT   = WAIT_CNT_W'(MEM_TIMEOUT);

  hz_state_e              state_q, state_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic                   mem_fault_q, mem_fault_d;
  logic [31:0]            stall_count_q, stall_count_d;

  logic load_use, raw_stall, data_stall, mem_wait, timeout;
  logic pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
  logic if_id_flush, id_ex_bubble, mem_wb_bubble;

  hazard_detect u_hazard_detect (
    .rs1_id      (bus.rs1_ID),
    .rs2_id      (bus.rs2_ID),
    .rs1_used_id (bus.rs1_used_ID),
    .rs2_used_id (bus.rs2_used_ID),
    .rd_ex       (bus.rd_EX),
    .we_ex       (bus.regfile_we_EX),
    .rd_sel_ex   (bus.rd_data_sel_EX),
    .rd_mem      (bus.rd_MEM),
    .we_mem      (bus.regfile_we_MEM),
    .load_use    (load_use),
    .raw_stall   (raw_stall)
  );

  assign data_stall = load_use || raw_stall;
  assign mem_wait   = bus.lsu_req_MEM && !bus.lsu_ack_MEM;
  assign timeout    = (state_q == ST_MEM_WAIT) && (wait_cnt_q == WAIT_LIMIT);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    wait_cnt_d    = '0;
    mem_fault_d   = 1'b0;
    pc_hold       = 1'b0;
    if_id_hold    = 1'b0;
    id_ex_hold    = 1'b0;
    ex_mem_hold   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;

    if (rst) begin
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (timeout) begin
      // Abandon the access: drain MEM with a bubble and resume fetching.
      mem_wb_bubble = 1'b1;
      state_d       = ST_RUN;
      flush_cnt_d   = '0;
    end else if (mem_wait) begin
      pc_hold       = 1'b1;
      if_id_hold    = 1'b1;
      id_ex_hold    = 1'b1;
      ex_mem_hold   = 1'b1;
      mem_wb_bubble = 1'b1;
      state_d       = ST_MEM_WAIT;
      wait_cnt_d    = wait_cnt_q + 1'b1;
      mem_fault_d   = (wait_cnt_q + 1'b1) == WAIT_LIMIT;
    end else if (bus.branch_taken_EX) begin
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      flush_cnt_d   = FLUSH_RELOAD;
      state_d       = (FLUSH_RELOAD == '0) ? ST_RUN : ST_REDIRECT;
    end else if (state_q == ST_REDIRECT) begin
      // ID only holds squashed slots while the redirect drains, so no hazard check here.
      if_id_flush   = 1'b1;
      flush_cnt_d   = flush_cnt_q - 1'b1;
      state_d       = (flush_cnt_q <= 1) ? ST_RUN : ST_REDIRECT;
    end else begin
      if (data_stall) begin
        pc_hold      = 1'b1;
        if_id_hold   = 1'b1;
        id_ex_bubble = 1'b1;
      end
      // Leaving MEM_WAIT resumes a redirect that the wait had frozen.
      state_d = (flush_cnt_q != '0) ? ST_REDIRECT : ST_RUN;
    end
  end

  assign stall_count_d = stall_count_q + {31'd0, pc_hold};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      flush_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      mem_fault_q   <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_fault_q   <= mem_fault_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.pc_hold       = pc_hold;
  assign bus.if_id_hold    = if_id_hold;
  assign bus.id_ex_hold    = id_ex_hold;
  assign bus.ex_mem_hold   = ex_mem_hold;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_bubble  = id_ex_bubble;
  assign bus.mem_wb_bubble = mem_wb_bubble;
  assign bus.mem_fault     = mem_fault_q && !rst;
  assign bus.stall_count   = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: directed scenarios then random traffic,
// each cycle's expectation produced by a cycle-level model of the stall/flush rules.
module tb_pipeline_hazard_controller;

  localparam int         FLUSH   = 2;
  localparam int         TMO     = 8;
  localparam logic [1:0] LSU_SEL = 2'd1;

  typedef struct packed {
    logic       rst;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       u1;
    logic       u2;
    logic [3:0] rd_ex;
    logic       we_ex;
    logic [1:0] sel_ex;
    logic [3:0] rd_mem;
    logic       we_mem;
    logic       br;
    logic       req;
    logic       ack;
  } stim_t;

  // ctl = {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush, id_ex_bubble, mem_wb_bubble}
  typedef struct packed {
    logic [6:0]  ctl;
    logic        fault;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_controller_if bus ();

  pipeline_hazard_controller #(
    .REDIRECT_FLUSH_CYCLES (FLUSH),
    .MEM_TIMEOUT           (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  // Model state: consecutive held cycles of the current memory wait, redirect slots
  // still owed, and cycles stalled since reset.
  int          m_waited = 0;
  int          m_slots  = 0;
  logic [31:0] m_stalls = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp_v);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic bit hazard(input stim_t s);
    bit hit_ex;
    hit_ex = s.we_ex && (s.rd_ex != 0) &&
             ((s.u1 && s.rs1 == s.rd_ex) || (s.u2 && s.rs2 == s.rd_ex));
`ifdef HAZARD_FORWARDING_EN
    return hit_ex && (s.sel_ex == LSU_SEL);
`else
    return hit_ex || (s.we_mem && (s.rd_mem != 0) &&
                      ((s.u1 && s.rs1 == s.rd_mem) || (s.u2 && s.rs2 == s.rd_mem)));
`endif
  endfunction

  task automatic step(input stim_t s, input bit push);
    exp_t e;
    bit   was_waiting;
    @(posedge clk);
    #1;
    rst                 = s.rst;
    bus.rs1_ID          = s.rs1;
    bus.rs2_ID          = s.rs2;
    bus.rs1_used_ID     = s.u1;
    bus.rs2_used_ID     = s.u2;
    bus.rd_EX           = s.rd_ex;
    bus.regfile_we_EX   = s.we_ex;
    bus.rd_data_sel_EX  = s.sel_ex;
    bus.rd_MEM          = s.rd_mem;
    bus.regfile_we_MEM  = s.we_mem;
    bus.branch_taken_EX = s.br;
    bus.lsu_req_MEM     = s.req;
    bus.lsu_ack_MEM     = s.ack;

    e.cnt   = m_stalls;
    e.fault = !s.rst && (m_waited == TMO);
    e.ctl   = 7'b0000000;
    if (s.rst) begin
      e.ctl    = 7'b0000111;
      m_waited = 0;
      m_slots  = 0;
      m_stalls = '0;
    end else if (m_waited == TMO) begin
      e.ctl    = 7'b0000001;
      m_waited = 0;
      m_slots  = 0;
    end else if (s.req && !s.ack) begin
      e.ctl    = 7'b1111001;
      m_waited = m_waited + 1;
    end else begin
      was_waiting = (m_waited > 0);
      m_waited    = 0;
      if (s.br) begin
        e.ctl   = 7'b0000110;
        m_slots = FLUSH - 1;
      end else if (m_slots > 0 && !was_waiting) begin
        e.ctl   = 7'b0000100;
        m_slots = m_slots - 1;
      end else if (hazard(s)) begin
        e.ctl   = 7'b1100010;
      end
    end
    if (e.ctl[6]) m_stalls = m_stalls + 1;
    if (push) exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ctl", 32'({bus.pc_hold, bus.if_id_hold, bus.id_ex_hold, bus.ex_mem_hold,
                          bus.if_id_flush, bus.id_ex_bubble, bus.mem_wb_bubble}), 32'(e.ctl));
        check("mem_fault", 32'(bus.mem_fault), 32'(e.fault));
        check("stall_count", bus.stall_count, e.cnt);
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    int    lat_left;
    bus.rs1_ID = '0; bus.rs2_ID = '0; bus.rs1_used_ID = 1'b0; bus.rs2_used_ID = 1'b0;
    bus.rd_EX = '0; bus.regfile_we_EX = 1'b0; bus.rd_data_sel_EX = '0;
    bus.rd_MEM = '0; bus.regfile_we_MEM = 1'b0;
    bus.branch_taken_EX = 1'b0; bus.lsu_req_MEM = 1'b0; bus.lsu_ack_MEM = 1'b0;

    s = idle(); s.rst = 1'b1; step(s, 1'b0);
    s = idle(); s.rst = 1'b1; step(s, 1'b1);

    // Load to x5 in EX, ID reads x5; the load then moves on to MEM.
    s = idle(); s.rd_ex = 4'd5; s.we_ex = 1'b1; s.sel_ex = LSU_SEL; s.rs1 = 4'd5; s.u1 = 1'b1;
    step(s, 1'b1);
    s = idle(); s.rd_mem = 4'd5; s.we_mem = 1'b1; s.rs1 = 4'd5; s.u1 = 1'b1; step(s, 1'b1);
    s = idle(); step(s, 1'b1);
    // ALU write to x3 seen in EX then in MEM.
    s = idle(); s.rd_ex = 4'd3; s.we_ex = 1'b1; s.rs2 = 4'd3; s.u2 = 1'b1; step(s, 1'b1);
    s = idle(); s.rd_mem = 4'd3; s.we_mem = 1'b1; s.rs2 = 4'd3; s.u2 = 1'b1; step(s, 1'b1);
    // x0 never creates a hazard.
    s = idle(); s.we_ex = 1'b1; s.sel_ex = LSU_SEL; s.u1 = 1'b1; s.we_mem = 1'b1; step(s, 1'b1);
    // Taken branch and its flush window.
    s = idle(); s.br = 1'b1; step(s, 1'b1);
    s = idle(); step(s, 1'b1);
    s = idle(); step(s, 1'b1);
    // Four-cycle memory wait with a branch held in EX, then the ack.
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.req = 1'b1; s.br = 1'b1; step(s, 1'b1);
    end
    s = idle(); s.req = 1'b1; s.ack = 1'b1; s.br = 1'b1; step(s, 1'b1);
    s = idle(); step(s, 1'b1);
    s = idle(); step(s, 1'b1);
    // Branch, then a wait that preempts the redirect mid-flush.
    s = idle(); s.br = 1'b1; step(s, 1'b1);
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.req = 1'b1; step(s, 1'b1);
    end
    s = idle(); s.req = 1'b1; s.ack = 1'b1; step(s, 1'b1);
    s = idle(); step(s, 1'b1);
    s = idle(); step(s, 1'b1);
    // Access that is never acknowledged runs into the watchdog.
    for (int i = 0; i < TMO + 1; i++) begin
      s = idle(); s.req = 1'b1; step(s, 1'b1);
    end
    s = idle(); step(s, 1'b1);
    s = idle(); step(s, 1'b1);
    // Reset pulsed in the middle of a memory wait.
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.req = 1'b1; step(s, 1'b1);
    end
    s = idle(); s.rst = 1'b1; s.req = 1'b1; step(s, 1'b1);
    s = idle(); step(s, 1'b1);
    s = idle(); step(s, 1'b1);

    lat_left = -1;
    for (int n = 0; n < 4000; n++) begin
      s        = idle();
      s.rst    = ($urandom_range(0, 199) == 0);
      s.rs1    = 4'($urandom_range(0, 3));
      s.rs2    = 4'($urandom_range(0, 3));
      s.u1     = 1'($urandom_range(0, 1));
      s.u2     = 1'($urandom_range(0, 1));
      s.rd_ex  = 4'($urandom_range(0, 3));
      s.we_ex  = 1'($urandom_range(0, 1));
      s.sel_ex = 2'($urandom_range(0, 3));
      s.rd_mem = 4'($urandom_range(0, 3));
      s.we_mem = 1'($urandom_range(0, 1));
      s.br     = ($urandom_range(0, 7) == 0);
      if (lat_left < 0 && $urandom_range(0, 5) == 0) lat_left = $urandom_range(0, 11);
      if (lat_left >= 0) begin
        s.req    = 1'b1;
        s.ack    = (lat_left == 0);
        lat_left = lat_left - 1;
      end
      step(s, 1'b1);
    end

    s = idle(); step(s, 1'b1);
    @(negedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
